boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Sequences memory port A of Mem4K between a program-load stream and core instruction fetch.
- While loading, holds the core in reset and writes incoming words to consecutive word addresses from BASE_ADDR. It then writes a terminator word, waits a settle interval, releases the core and hands port A to the core's fetch bus.
- Replaces the ad-hoc load-then-release sequencing in the system benches and is synthesizable.

Parameters:
BASE_ADDR, 32'h0000_0800, byte address of the first program word
MAX_WORDS, 511, maximum program words accepted; the terminator occupies word MAX_WORDS
TERM_WORD, 32'hFFFF_0000, word written after the last program word
SETTLE_CYC, 2, cycles core_rst stays high after the terminator write (range 1..15)

Ports:
clk  in  1  single clock, shared with Mem4K
rst  in  1  asynchronous, active-low reset
ld_valid  in  1  load word valid
ld_ready  out  1  loader accepts the word this cycle
ld_data  in  32  program word
ld_last  in  1  qualifies the final program word
reload  in  1  single-cycle pulse; in RUN, restarts loading
core_rst  out  1  active-high reset to the core
I_ABus  in  32  core fetch address
I_DBus  out  32  fetched instruction to the core
A_EnWR  out  1  port A mode: `MM_ENB_W` or `MM_ENB_R` from MemIO.v
A_ABus  out  32  port A byte address
A_DBusW  out  32  port A write data
A_DBusR  in  32  port A read data
done  out  1  high in RUN
err  out  1  sticky overflow flag

Behaviour:
- Reset (rst low, asynchronous): state=LOAD, wcnt=0, settle counter=0, err=0. Outputs during reset: core_rst=1, done=0, ld_ready=0, A_EnWR=`MM_ENB_R`.
- States: LOAD, TERM, SETTLE, RUN, ERR. Transitions occur on posedge clk.
- LOAD:
  - ld_ready=1. A_ABus=BASE_ADDR+4*wcnt. A_DBusW=ld_data.
  - A_EnWR=`MM_ENB_W` exactly when ld_valid&&ld_ready (combinational); otherwise `MM_ENB_R`.
  - On accept: wcnt+1.
  - Accept with ld_last=1 -> TERM.
  - Accept with ld_last=0 when wcnt==MAX_WORDS-1 -> ERR. That word is still written.
- TERM:
  - One cycle. ld_ready=0. A_EnWR=`MM_ENB_W`. A_ABus=BASE_ADDR+4*wcnt. A_DBusW=TERM_WORD.
  - Next state: SETTLE, with settle counter=0.
- SETTLE:
  - A_EnWR=`MM_ENB_R`. core_rst=1.
  - Counter increments each cycle; when it reaches SETTLE_CYC-1 -> RUN.
  - Total time in SETTLE is SETTLE_CYC cycles.
- RUN:
  - core_rst=0, done=1.
  - A_EnWR=`MM_ENB_R`. A_ABus=I_ABus and I_DBus=A_DBusR, both combinational.
  - reload=1 -> LOAD with wcnt=0. core_rst returns to 1 in the first LOAD cycle.
- ERR:
  - err=1 (sticky until rst). ld_ready=0. core_rst=1. A_EnWR=`MM_ENB_R`. reload is ignored.
  - The only exit is rst.
- I_DBus outside RUN: 32'h0000_0013 (NOP).
- ld_valid without ld_ready is never a write.
- ld_last on a zero-length program: not possible, since the first accepted word carries it. One-word programs are legal: word at BASE_ADDR, terminator at BASE_ADDR+4.
- reload outside RUN is ignored.
- rst during LOAD/TERM/SETTLE/RUN aborts immediately: core_rst=1, port A to `MM_ENB_R`. Words already written stay in memory.
- wcnt is 10 bits wide; its top value never exceeds MAX_WORDS.
- core_rst is a registered output (glitch-free); done and err are registered.

Test Plan:
1. Stream 3 words (0x00500093, 0x00100113, 0x00008067, last on the third), with ld_valid held high -> writes at 0x800, 0x804, 0x808. Terminator 0xFFFF0000 at 0x80C on the 4th write cycle. core_rst falls 2 cycles after TERM. done=1.
2. Same program with ld_valid toggling 1,0,1,0 -> identical memory image. No writes occur in the gap cycles.
3. Stream 511 words with no ld_last -> 511 writes, then err=1, core_rst stays 1, ld_ready=0. A later reload pulse has no effect.
4. In RUN, drive I_ABus=0x804 -> I_DBus=0x00100113 with Mem4K read timing. Pulse reload -> core_rst=1 the next cycle. A new 1-word load writes 0x800 and a terminator at 0x804.
5. Assert rst low mid-SETTLE -> core_rst=1, done=0 and A_EnWR=`MM_ENB_R` immediately (asynchronous). After release, state=LOAD with wcnt=0.
6. One-word program (0x00008067, ld_last=1) -> writes 0x800=0x00008067 and 0x804=0xFFFF0000. RUN is reached 1+1+SETTLE_CYC cycles after the accept.

Source files
------------

// File: rtl/boot_loader_if.sv
// Program-load stream between a loader source (master) and the boot loader (slave).
// The source drives valid/data/last and the loader answers with ready.
interface boot_loader_if;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_data;
   logic        ld_last;

   modport master (output ld_valid, ld_data, ld_last, input ld_ready);
   modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/boot_loader.sv
// Owns memory port A: fills it from the load stream with the core held in reset,
// appends a terminator, waits a settle interval, then passes port A to core fetch.
`ifndef MM_ENB_W
`define MM_ENB_W 1'b1
`endif
`ifndef MM_ENB_R
`define MM_ENB_R 1'b0
`endif

module boot_loader #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
   parameter int          MAX_WORDS  = 511,
   parameter logic [31:0] TERM_WORD  = 32'hFFFF_0000,
   parameter int          SETTLE_CYC = 2
) (
   input  logic         clk,
   input  logic         rst,
   boot_loader_if.slave ld,
   input  logic         reload,
   output logic         core_rst,
   input  logic [31:0]  I_ABus,
   output logic [31:0]  I_DBus,
   output logic         A_EnWR,
   output logic [31:0]  A_ABus,
   output logic [31:0]  A_DBusW,
   input  logic [31:0]  A_DBusR,
   output logic         done,
   output logic         err
);
   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
   localparam logic [9:0]  LAST_IDX   = 10'(MAX_WORDS - 1);
   localparam logic [3:0]  SETTLE_END = 4'(SETTLE_CYC - 1);

   typedef enum logic [2:0] {LOAD, TERM, SETTLE, RUN, ERR} state_t;

   state_t      state;
   logic [9:0]  wcnt;
   logic [3:0]  settle_cnt;
   logic        accept;
   logic [31:0] word_addr;

   // Ready is gated by rst so nothing is accepted or written while reset is held.
   assign ld.ld_ready = rst && (state == LOAD);
   assign accept      = ld.ld_valid && ld.ld_ready;
   assign word_addr   = BASE_ADDR + {20'd0, wcnt, 2'b00};

   always_comb begin
      A_EnWR  = `MM_ENB_R;
      A_ABus  = word_addr;
      A_DBusW = ld.ld_data;
      I_DBus  = NOP_WORD;
      case (state)
         LOAD: if (accept) A_EnWR = `MM_ENB_W;
         TERM: begin
            A_EnWR  = `MM_ENB_W;
            A_DBusW = TERM_WORD;
         end
         RUN: begin
            A_ABus = I_ABus;
            I_DBus = A_DBusR;
         end
         default: ;
      endcase
   end

   // core_rst/done/err are updated together with the state change so they
   // always line up with the state they describe and never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= LOAD;
         wcnt       <= 10'd0;
         settle_cnt <= 4'd0;
         err        <= 1'b0;
         core_rst   <= 1'b1;
         done       <= 1'b0;
      end else begin
         case (state)
            LOAD: if (accept) begin
               wcnt <= wcnt + 10'd1;
               if (ld.ld_last) begin
                  state <= TERM;
               end else if (wcnt == LAST_IDX) begin
                  state <= ERR;
                  err   <= 1'b1;
               end
            end
            TERM: begin
               state      <= SETTLE;
               settle_cnt <= 4'd0;
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_END) begin
                  state    <= RUN;
                  core_rst <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            RUN: if (reload) begin
               state    <= LOAD;
               wcnt     <= 10'd0;
               core_rst <= 1'b1;
               done     <= 1'b0;
            end
            ERR: ;
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_boot_loader.sv
// Scoreboarded bench for boot_loader: a reference model queues the expected port-A
// writes and memory image; a negedge monitor pops and compares every write.
module tb_boot_loader;
   localparam logic [31:0] BASE_ADDR  = 32'h0000_0800;
   localparam int          MAX_WORDS  = 511;
   localparam logic [31:0] TERM_WORD  = 32'hFFFF_0000;
   localparam int          SETTLE_CYC = 2;
   localparam logic        ENB_W      = 1'b1;
   localparam logic        ENB_R      = 1'b0;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
   localparam int          BASE_IDX   = 32'h800 / 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        reload = 1'b0;
   logic        core_rst, A_EnWR, done, err;
   logic [31:0] I_ABus = 32'd0;
   logic [31:0] I_DBus, A_ABus, A_DBusW, A_DBusR;
   logic        mem_clear = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem     [1024];
   logic [31:0] exp_img [1024];
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] prog[$];

   boot_loader_if ld_if ();

   boot_loader #(
      .BASE_ADDR (BASE_ADDR),
      .MAX_WORDS (MAX_WORDS),
      .TERM_WORD (TERM_WORD),
      .SETTLE_CYC(SETTLE_CYC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ld      (ld_if),
      .reload  (reload),
      .core_rst(core_rst),
      .I_ABus  (I_ABus),
      .I_DBus  (I_DBus),
      .A_EnWR  (A_EnWR),
      .A_ABus  (A_ABus),
      .A_DBusW (A_DBusW),
      .A_DBusR (A_DBusR),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Synchronous 4 KB memory standing in for Mem4K port A.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      end else if (A_EnWR == ENB_W) begin
         mem[A_ABus[11:2]] <= A_DBusW;
      end
      A_DBusR <= mem[A_ABus[11:2]];
   end

   // Every port-A write must match the head of the expected-write queue.
   always @(negedge clk) begin
      if (rst && A_EnWR == ENB_W) begin
         checks++;
         if (exp_addr_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_write addr=%h data=%h", A_ABus, A_DBusW);
         end else begin
            logic [31:0] ea, ed;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (A_ABus !== ea || A_DBusW !== ed) begin
               errors++;
               $display("[TB] FAIL write got addr=%h data=%h want addr=%h data=%h",
                        A_ABus, A_DBusW, ea, ed);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Reference model: word k of a program lands at BASE_ADDR + 4k.
   task automatic expectWrite(input int k, input logic [31:0] data);
      exp_addr_q.push_back(BASE_ADDR + 32'(4 * k));
      exp_data_q.push_back(data);
      exp_img[BASE_IDX + k] = data;
   endtask

   task automatic clearMem();
      @(posedge clk); #1 mem_clear = 1'b1;
      @(posedge clk); #1 mem_clear = 1'b0;
      for (int i = 0; i < 1024; i++) exp_img[i] = 32'd0;
   endtask

   // gap_mode 0: valid held high, 1: valid alternates, 2: random gaps and random reload.
   task automatic applyStimulus(input bit with_last, input int gap_mode);
      int n;
      n = prog.size();
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
            ld_if.ld_valid = 1'b0;
            ld_if.ld_data  = $urandom;
            ld_if.ld_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         if (gap_mode == 2) reload = 1'($urandom_range(0, 1));
         ld_if.ld_valid = 1'b1;
         ld_if.ld_data  = prog[i];
         ld_if.ld_last  = with_last && (i == n - 1);
         expectWrite(i, prog[i]);
         if (with_last && i == n - 1) expectWrite(n, TERM_WORD);
         @(negedge clk);
         checkOutput("ld_ready_in_load", 32'(ld_if.ld_ready), 32'd1);
         checkOutput("i_dbus_nop_in_load", I_DBus, NOP_WORD);
         @(posedge clk); #1;
      end
      ld_if.ld_valid = 1'b0;
      ld_if.ld_last  = 1'b0;
      reload         = 1'b0;
   endtask

   // Called in the TERM cycle; RUN must begin 1 + SETTLE_CYC cycles later.
   task automatic waitRun(input string name);
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (core_rst && cyc < 50);
      checkOutput({name, "_run_latency"}, 32'(cyc), 32'(1 + 1 + SETTLE_CYC));
      checkOutput({name, "_done"}, 32'(done), 32'd1);
      checkOutput({name, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
   endtask

   task automatic checkImage(input string name);
      int bad;
      bad = 0;
      for (int i = BASE_IDX; i < 1024; i++) if (mem[i] !== exp_img[i]) bad++;
      checkOutput({name, "_image_mismatches"}, 32'(bad), 32'd0);
   endtask

   task automatic readCheck(input string name, input int idx);
      @(posedge clk); #1 I_ABus = 32'(idx * 4);
      @(posedge clk);
      @(negedge clk);
      checkOutput(name, I_DBus, exp_img[idx]);
   endtask

   task automatic doReload(input string name);
      @(posedge clk); #1 reload = 1'b1;
      @(posedge clk); #1 reload = 1'b0;
      @(negedge clk);
      checkOutput({name, "_core_rst"}, 32'(core_rst), 32'd1);
      checkOutput({name, "_done"}, 32'(done), 32'd0);
      checkOutput({name, "_ld_ready"}, 32'(ld_if.ld_ready), 32'd1);
   endtask

   initial begin
      int n;
      ld_if.ld_valid = 1'b0;
      ld_if.ld_data  = 32'd0;
      ld_if.ld_last  = 1'b0;
      for (int i = 0; i < 1024; i++) exp_img[i] = 32'd0;

      // Reset: a valid word offered during reset must not be accepted.
      repeat (2) @(posedge clk);
      #1 mem_clear = 1'b0;
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = 32'hDEAD_BEEF;
      #1;
      checkOutput("reset_core_rst", 32'(core_rst), 32'd1);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      checkOutput("reset_ld_ready", 32'(ld_if.ld_ready), 32'd0);
      checkOutput("reset_a_enwr", 32'(A_EnWR), 32'(ENB_R));
      checkOutput("reset_i_dbus", I_DBus, NOP_WORD);
      ld_if.ld_valid = 1'b0;
      @(negedge clk) rst = 1'b1;

      // Three-word program, valid held high.
      prog = '{32'h0050_0093, 32'h0010_0113, 32'h0000_8067};
      applyStimulus(1'b1, 0);
      waitRun("t1");
      checkImage("t1");

      // Fetch through port A while running.
      readCheck("t4_fetch_804", BASE_IDX + 1);
      for (int k = 0; k < 3; k++) readCheck("t4_fetch_rand", BASE_IDX + $urandom_range(0, 3));

      // Same program with gaps between words.
      doReload("t4_reload");
      clearMem();
      applyStimulus(1'b1, 1);
      waitRun("t2");
      checkImage("t2");

      // One-word program.
      doReload("t6_reload");
      clearMem();
      prog = '{32'h0000_8067};
      applyStimulus(1'b1, 0);
      waitRun("t6");
      checkImage("t6");

      // Random programs with random gaps and stray reload pulses.
      for (int r = 0; r < 4; r++) begin
         doReload("rnd_reload");
         clearMem();
         n = $urandom_range(1, 24);
         prog.delete();
         for (int i = 0; i < n; i++) prog.push_back($urandom);
         applyStimulus(1'b1, 2);
         waitRun("rnd");
         checkImage("rnd");
         readCheck("rnd_fetch", BASE_IDX + $urandom_range(0, n));
      end

      // Asynchronous reset while running.
      @(posedge clk); #1 rst = 1'b0;
      #1;
      checkOutput("rst_run_core_rst", 32'(core_rst), 32'd1);
      checkOutput("rst_run_done", 32'(done), 32'd0);
      checkOutput("rst_run_a_enwr", 32'(A_EnWR), 32'(ENB_R));
      checkOutput("rst_run_i_dbus", I_DBus, NOP_WORD);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;

      // Reset aborts SETTLE; loading restarts from word 0 afterwards.
      prog = '{$urandom};
      applyStimulus(1'b1, 0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("settle_core_rst", 32'(core_rst), 32'd1);
      checkOutput("settle_a_enwr", 32'(A_EnWR), 32'(ENB_R));
      #1 rst = 1'b0;
      #1;
      checkOutput("rst_settle_core_rst", 32'(core_rst), 32'd1);
      checkOutput("rst_settle_done", 32'(done), 32'd0);
      checkOutput("rst_settle_a_enwr", 32'(A_EnWR), 32'(ENB_R));
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      checkOutput("after_rst_ld_ready", 32'(ld_if.ld_ready), 32'd1);
      prog = '{$urandom, $urandom};
      applyStimulus(1'b1, 0);
      waitRun("after_rst");
      checkImage("after_rst");

      // Overflow: MAX_WORDS words without last.
      doReload("ovf_reload");
      clearMem();
      prog.delete();
      for (int i = 0; i < MAX_WORDS; i++) prog.push_back($urandom);
      applyStimulus(1'b0, 0);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = $urandom;
      @(negedge clk);
      checkOutput("ovf_err", 32'(err), 32'd1);
      checkOutput("ovf_ld_ready", 32'(ld_if.ld_ready), 32'd0);
      checkOutput("ovf_core_rst", 32'(core_rst), 32'd1);
      checkOutput("ovf_a_enwr", 32'(A_EnWR), 32'(ENB_R));
      @(posedge clk); #1 reload = 1'b1;
      @(posedge clk); #1 reload = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("ovf_reload_err", 32'(err), 32'd1);
      checkOutput("ovf_reload_ld_ready", 32'(ld_if.ld_ready), 32'd0);
      checkOutput("ovf_reload_core_rst", 32'(core_rst), 32'd1);
      checkOutput("ovf_reload_done", 32'(done), 32'd0);
      ld_if.ld_valid = 1'b0;
      checkImage("ovf");
      #1 rst = 1'b0;
      #1;
      checkOutput("ovf_rst_err", 32'(err), 32'd0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      checkOutput("ovf_rst_ld_ready", 32'(ld_if.ld_ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
